grf_multiport: RTL and testbench
================================

Name: grf_multiport

Overview:
- Parametrised general-purpose register file, successor of the single-write, two-read GRF in the MIPS datapath.
- Adds:
  - configurable data/address width and read-port count
  - optional write-to-read bypass
  - per-register pending (busy) scoreboard for hazard detection
  - registered write-trace output that replaces simulation-only printing
- Sits between decode (read ports, busy query/set) and writeback (write port).

Parameters:
- DATA_W, 32, register data width in bits.
- ADDR_W, 5, register address width; NREG = 2**ADDR_W registers.
- NREAD, 2, number of independent read ports (1..4).
- BYPASS, 1, 1 = same-cycle write data forwarded to matching reads; 0 = reads return stored value only.

Ports:
- Clk  in  1  clock, all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- WE  in  1  write enable.
- A3  in  ADDR_W  write address.
- WD  in  DATA_W  write data.
- WPC  in  32  PC of the writing instruction, trace only.
- RA  in  NREAD*ADDR_W  read addresses; port i at [i*ADDR_W +: ADDR_W].
- RD  out  NREAD*DATA_W  read data; port i at [i*DATA_W +: DATA_W].
- SetEn  in  1  mark a destination register pending.
- SetA  in  ADDR_W  register to mark pending.
- RBusy  out  NREAD  per read port: addressed register is pending.
- TrValid  out  1  trace record valid.
- TrPC  out  32  trace PC.
- TrAddr  out  ADDR_W  trace register index.
- TrData  out  DATA_W  trace data.
- WrCount  out  32  number of committed writes since reset.

Behaviour:
- Reset is synchronous, active-high, clock Clk.
- On a Reset edge:
  - all NREG registers are cleared to 0
  - all busy bits are cleared
  - TrValid, TrPC, TrAddr, TrData and WrCount go to 0
- Reset overrides any concurrent WE or SetEn.
- Commit condition: WE=1 and A3!=0 at a rising edge. On commit:
  - reg[A3] <= WD
  - WrCount increments and wraps 2^32-1 -> 0
- WE with A3=0 is ignored: no state change, no trace, no count.
- Register 0 always reads 0 and can never be marked busy.
- Reads are combinational, zero latency, per port i:
  - RA_i = 0 -> RD_i = 0.
  - BYPASS=1, WE=1, A3=RA_i, RA_i!=0 -> RD_i = WD (same cycle).
  - Otherwise RD_i = reg[RA_i].
- Several ports may read the same address; each returns an identical value.
- Scoreboard, one busy bit per register:
  - Edge with SetEn=1 and SetA!=0: busy[SetA] <= 1.
  - Edge with commit to A3: busy[A3] <= 0.
  - SetA = A3 on the same edge: set wins; busy stays 1 because a new producer was issued.
  - SetEn with SetA=0 is ignored.
- RBusy_i:
  - RBusy_i = busy[RA_i] & (RA_i!=0).
  - When BYPASS=1, a same-cycle commit to RA_i masks it to 0, since data is forwarded.
- Trace stage, one-cycle pipeline:
  - Edge with a commit: TrValid <= 1, TrPC <= WPC, TrAddr <= A3, TrData <= WD.
  - Any other edge: TrValid <= 0; other trace fields hold their value.
  - A trace record is therefore visible the cycle after the write.
- Back-to-back writes to the same register: the last write wins. Each write produces its own trace record on consecutive cycles.
- Reset mid-stream: a commit coincident with Reset is discarded, with no trace record. TrValid is 0 the cycle after.

Test Plan:
- Reset, then RA0=5, RA1=31 -> RD0=0, RD1=0, RBusy=0, WrCount=0, TrValid=0.
- WE=1, A3=8, WD=0x12345678, WPC=0x3000; next cycle RA0=8 -> RD0=0x12345678; TrValid=1, TrPC=0x3000, TrAddr=8, TrData=0x12345678; WrCount=1.
- BYPASS=1: WE=1, A3=9, WD=0xDEADBEEF, RA1=9 in the same cycle -> RD1=0xDEADBEEF before the edge. BYPASS=0: RD1=old value 0.
- WE=1, A3=0, WD=0xFFFFFFFF -> RD for addr 0 stays 0, TrValid=0 next cycle, WrCount unchanged.
- Scoreboard:
  - SetEn=1, SetA=4 -> next cycle RA0=4 gives RBusy0=1.
  - Commit to 4 with BYPASS=1 -> RBusy0=0 in that cycle; busy cleared after the edge.
  - Simultaneous SetEn/SetA=4 and commit A3=4 -> busy[4] remains 1.
- Reset asserted together with WE=1, A3=3 and SetEn=1, SetA=3 -> reg3=0, busy[3]=0, TrValid=0, WrCount=0.

Source files
------------

// File: rtl/grf_multiport.sv
// Multi-port general-purpose register file with optional write-to-read bypass,
// a per-register pending scoreboard and a registered write-trace output.
module grf_multiport #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREAD  = 2,
    parameter int BYPASS = 1
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     WE,
    input  logic [ADDR_W-1:0]        A3,
    input  logic [DATA_W-1:0]        WD,
    input  logic [31:0]              WPC,
    input  logic [NREAD*ADDR_W-1:0]  RA,
    output logic [NREAD*DATA_W-1:0]  RD,
    input  logic                     SetEn,
    input  logic [ADDR_W-1:0]        SetA,
    output logic [NREAD-1:0]         RBusy,
    output logic                     TrValid,
    output logic [31:0]              TrPC,
    output logic [ADDR_W-1:0]        TrAddr,
    output logic [DATA_W-1:0]        TrData,
    output logic [31:0]              WrCount
);

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   busy;
    logic              commit;
    logic              set_ok;
    logic [ADDR_W-1:0] ra;

    // Register 0 is never written and never marked busy.
    assign commit = WE && (A3 != '0);
    assign set_ok = SetEn && (SetA != '0);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            // NOTE: the storage array is reset explicitly because register contents must read 0 after reset.
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            busy    <= '0;
            TrValid <= 1'b0;
            TrPC    <= '0;
            TrAddr  <= '0;
            TrData  <= '0;
            WrCount <= '0;
        end else begin
            // NOTE: non-blocking assignments; the later busy write below overrides the clear.
            if (commit) begin
                regs[A3] <= WD;
                busy[A3] <= 1'b0;
                WrCount  <= WrCount + 32'd1;
                TrPC     <= WPC;
                TrAddr   <= A3;
                TrData   <= WD;
            end
            // A newly issued producer keeps the register pending.
            if (set_ok) busy[SetA] <= 1'b1;
            TrValid <= commit;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        RD    = '0;
        RBusy = '0;
        ra    = '0;
        for (int i = 0; i < NREAD; i++) begin
            ra = RA[i*ADDR_W +: ADDR_W];
            if (ra != '0) begin
                if ((BYPASS != 0) && commit && (A3 == ra)) begin
                    RD[i*DATA_W +: DATA_W] = WD;
                    RBusy[i]               = 1'b0;
                end else begin
                    RD[i*DATA_W +: DATA_W] = regs[ra];
                    RBusy[i]               = busy[ra];
                end
            end
        end
    end

endmodule

// File: tb/tb_grf_multiport.sv
// Directed bench for grf_multiport: one BYPASS=1 and one BYPASS=0 instance share the inputs.
module tb_grf_multiport;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        WE;
    logic [4:0]  A3;
    logic [31:0] WD;
    logic [31:0] WPC;
    logic [9:0]  RA;
    logic        SetEn;
    logic [4:0]  SetA;

    logic [63:0] rd_b, rd_n;
    logic [1:0]  rbusy_b, rbusy_n;
    logic        trv_b, trv_n;
    logic [31:0] trpc_b, trpc_n;
    logic [4:0]  tra_b, tra_n;
    logic [31:0] trd_b, trd_n;
    logic [31:0] wrc_b, wrc_n;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    grf_multiport #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .BYPASS(1)) dut (
        .Clk(Clk), .Reset(Reset), .WE(WE), .A3(A3), .WD(WD), .WPC(WPC),
        .RA(RA), .RD(rd_b), .SetEn(SetEn), .SetA(SetA), .RBusy(rbusy_b),
        .TrValid(trv_b), .TrPC(trpc_b), .TrAddr(tra_b), .TrData(trd_b), .WrCount(wrc_b)
    );

    grf_multiport #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .BYPASS(0)) dut_nb (
        .Clk(Clk), .Reset(Reset), .WE(WE), .A3(A3), .WD(WD), .WPC(WPC),
        .RA(RA), .RD(rd_n), .SetEn(SetEn), .SetA(SetA), .RBusy(rbusy_n),
        .TrValid(trv_n), .TrPC(trpc_n), .TrAddr(tra_n), .TrData(trd_n), .WrCount(wrc_n)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        WE = 1'b0; A3 = '0; WD = '0; WPC = '0; SetEn = 1'b0; SetA = '0;
    endtask

    task automatic test_reset();
        idle();
        Reset = 1'b1;
        RA = '0;
        tick();
        tick();
        Reset = 1'b0;
        RA = {5'd31, 5'd5};
        #1;
        checks++; if (rd_b[31:0] !== 32'h0) begin errors++; $display("FAIL reset_rd0: got %h want %h", rd_b[31:0], 32'h0); end
        checks++; if (rd_b[63:32] !== 32'h0) begin errors++; $display("FAIL reset_rd1: got %h want %h", rd_b[63:32], 32'h0); end
        checks++; if (rbusy_b !== 2'b00) begin errors++; $display("FAIL reset_rbusy: got %b want 00", rbusy_b); end
        checks++; if (wrc_b !== 32'd0) begin errors++; $display("FAIL reset_wrcount: got %0d want 0", wrc_b); end
        checks++; if (trv_b !== 1'b0) begin errors++; $display("FAIL reset_trvalid: got %b want 0", trv_b); end
    endtask

    task automatic test_write();
        WE = 1'b1; A3 = 5'd8; WD = 32'h1234_5678; WPC = 32'h3000;
        tick();
        idle();
        RA = {5'd0, 5'd8};
        #1;
        checks++; if (rd_b[31:0] !== 32'h1234_5678) begin errors++; $display("FAIL write_rd0: got %h want 12345678", rd_b[31:0]); end
        checks++; if (trv_b !== 1'b1) begin errors++; $display("FAIL write_trvalid: got %b want 1", trv_b); end
        checks++; if (trpc_b !== 32'h3000) begin errors++; $display("FAIL write_trpc: got %h want 3000", trpc_b); end
        checks++; if (tra_b !== 5'd8) begin errors++; $display("FAIL write_traddr: got %0d want 8", tra_b); end
        checks++; if (trd_b !== 32'h1234_5678) begin errors++; $display("FAIL write_trdata: got %h want 12345678", trd_b); end
        checks++; if (wrc_b !== 32'd1) begin errors++; $display("FAIL write_wrcount: got %0d want 1", wrc_b); end
        tick();
        checks++; if (trv_b !== 1'b0) begin errors++; $display("FAIL write_trvalid_drop: got %b want 0", trv_b); end
        checks++; if (trd_b !== 32'h1234_5678) begin errors++; $display("FAIL write_trdata_hold: got %h want 12345678", trd_b); end
    endtask

    task automatic test_bypass();
        WE = 1'b1; A3 = 5'd9; WD = 32'hDEAD_BEEF; WPC = 32'h3004;
        RA = {5'd9, 5'd8};
        #1;
        checks++; if (rd_b[63:32] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_rd1: got %h want deadbeef", rd_b[63:32]); end
        checks++; if (rd_n[63:32] !== 32'h0) begin errors++; $display("FAIL nobypass_rd1: got %h want 0", rd_n[63:32]); end
        checks++; if (rd_b[31:0] !== 32'h1234_5678) begin errors++; $display("FAIL bypass_rd0: got %h want 12345678", rd_b[31:0]); end
        tick();
        idle();
        #1;
        checks++; if (rd_n[63:32] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL nobypass_rd1_after: got %h want deadbeef", rd_n[63:32]); end
        checks++; if (wrc_b !== 32'd2) begin errors++; $display("FAIL bypass_wrcount: got %0d want 2", wrc_b); end
        RA = {5'd8, 5'd8};
        #1;
        checks++; if (rd_b[63:32] !== 32'h1234_5678 || rd_b[31:0] !== 32'h1234_5678) begin errors++; $display("FAIL same_addr: got %h want 12345678 on both ports", rd_b); end
    endtask

    task automatic test_zero_write();
        tick();
        WE = 1'b1; A3 = 5'd0; WD = 32'hFFFF_FFFF; WPC = 32'h3008;
        RA = {5'd8, 5'd0};
        #1;
        checks++; if (rd_b[31:0] !== 32'h0) begin errors++; $display("FAIL zero_bypass_rd0: got %h want 0", rd_b[31:0]); end
        tick();
        idle();
        #1;
        checks++; if (rd_b[31:0] !== 32'h0) begin errors++; $display("FAIL zero_rd0: got %h want 0", rd_b[31:0]); end
        checks++; if (trv_b !== 1'b0) begin errors++; $display("FAIL zero_trvalid: got %b want 0", trv_b); end
        checks++; if (wrc_b !== 32'd2) begin errors++; $display("FAIL zero_wrcount: got %0d want 2", wrc_b); end
    endtask

    task automatic test_scoreboard();
        SetEn = 1'b1; SetA = 5'd4;
        tick();
        idle();
        RA = {5'd0, 5'd4};
        #1;
        checks++; if (rbusy_b !== 2'b01) begin errors++; $display("FAIL sb_set: got %b want 01", rbusy_b); end
        WE = 1'b1; A3 = 5'd4; WD = 32'h0000_A5A5; WPC = 32'h3010;
        #1;
        checks++; if (rbusy_b[0] !== 1'b0) begin errors++; $display("FAIL sb_bypass_mask: got %b want 0", rbusy_b[0]); end
        checks++; if (rbusy_n[0] !== 1'b1) begin errors++; $display("FAIL sb_nobypass_busy: got %b want 1", rbusy_n[0]); end
        checks++; if (rd_b[31:0] !== 32'h0000_A5A5) begin errors++; $display("FAIL sb_bypass_rd0: got %h want a5a5", rd_b[31:0]); end
        tick();
        idle();
        #1;
        checks++; if (rbusy_b[0] !== 1'b0 || rbusy_n[0] !== 1'b0) begin errors++; $display("FAIL sb_clear: got %b/%b want 0/0", rbusy_b[0], rbusy_n[0]); end
        SetEn = 1'b1; SetA = 5'd4;
        WE = 1'b1; A3 = 5'd4; WD = 32'h0000_0077; WPC = 32'h3014;
        tick();
        idle();
        #1;
        checks++; if (rbusy_b[0] !== 1'b1 || rbusy_n[0] !== 1'b1) begin errors++; $display("FAIL sb_set_wins: got %b/%b want 1/1", rbusy_b[0], rbusy_n[0]); end
        checks++; if (rd_b[31:0] !== 32'h77) begin errors++; $display("FAIL sb_set_wins_rd0: got %h want 77", rd_b[31:0]); end
        checks++; if (wrc_b !== 32'd4) begin errors++; $display("FAIL sb_wrcount: got %0d want 4", wrc_b); end
    endtask

    task automatic test_back_to_back();
        WE = 1'b1; A3 = 5'd10; WD = 32'h1; WPC = 32'h100;
        tick();
        WD = 32'h2; WPC = 32'h104;
        #1;
        checks++; if (trv_b !== 1'b1 || trd_b !== 32'h1 || trpc_b !== 32'h100) begin errors++; $display("FAIL b2b_first: got v=%b d=%h pc=%h want 1/1/100", trv_b, trd_b, trpc_b); end
        tick();
        idle();
        RA = {5'd0, 5'd10};
        #1;
        checks++; if (trv_b !== 1'b1 || trd_b !== 32'h2 || trpc_b !== 32'h104) begin errors++; $display("FAIL b2b_second: got v=%b d=%h pc=%h want 1/2/104", trv_b, trd_b, trpc_b); end
        checks++; if (rd_b[31:0] !== 32'h2) begin errors++; $display("FAIL b2b_last_wins: got %h want 2", rd_b[31:0]); end
        checks++; if (wrc_b !== 32'd6) begin errors++; $display("FAIL b2b_wrcount: got %0d want 6", wrc_b); end
    endtask

    task automatic test_reset_mid();
        WE = 1'b1; A3 = 5'd3; WD = 32'h33; SetEn = 1'b1; SetA = 5'd3;
        tick();
        Reset = 1'b1;
        WE = 1'b1; A3 = 5'd3; WD = 32'h99; WPC = 32'h200; SetEn = 1'b1; SetA = 5'd3;
        tick();
        Reset = 1'b0;
        idle();
        RA = {5'd8, 5'd3};
        #1;
        checks++; if (rd_b[31:0] !== 32'h0) begin errors++; $display("FAIL rst_reg3: got %h want 0", rd_b[31:0]); end
        checks++; if (rbusy_b[0] !== 1'b0) begin errors++; $display("FAIL rst_busy3: got %b want 0", rbusy_b[0]); end
        checks++; if (trv_b !== 1'b0) begin errors++; $display("FAIL rst_trvalid: got %b want 0", trv_b); end
        checks++; if (wrc_b !== 32'd0) begin errors++; $display("FAIL rst_wrcount: got %0d want 0", wrc_b); end
        checks++; if (rd_b[63:32] !== 32'h0) begin errors++; $display("FAIL rst_reg8: got %h want 0", rd_b[63:32]); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_bypass();
        test_zero_write();
        test_scoreboard();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
